// File: rtl/result_arbiter_pkg.sv
// Shared constants for the worker-result path: result word width and
// destination option codes carried inside result words.
package result_arbiter_pkg;

  localparam int WR_WIDTH = 32;

  localparam logic [1:0] DEST_OPTION_DISPATCH = 2'd0;
  localparam logic [1:0] DEST_OPTION_MEMORY   = 2'd1;
  localparam logic [1:0] DEST_OPTION_HOST     = 2'd2;
  localparam logic [1:0] DEST_OPTION_DROP     = 2'd3;

endpackage

// File: rtl/result_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first set request at or after
// last_grant+1 (mod N) by rotating a doubled copy of the request vector.
module rr_picker
  import result_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic            found,
  output logic [ID_W-1:0] grant
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             start;
  int             pos;
  int             sum;

  always_comb begin
    dbl   = {req, req};
    start = (int'(last_grant) >= N - 1) ? 0 : int'(last_grant) + 1;
    rot   = N'(dbl >> start);
    pos   = 0;
    // Scan high to low so the lowest offset from the start point wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    sum   = start + pos;
    if (sum >= N) sum = sum - N;
    found = |req;
    grant = ID_W'(sum);
  end

endmodule

// File: rtl/result_arbiter.sv
// Round-robin merge of per-worker result streams into one registered
// valid/ready output toward the dispatcher; one result every 3 cycles at best.
module result_arbiter
  import result_arbiter_pkg::*;
#(
  parameter int NUM_WORKERS         = 4,
  parameter int WORKER_RESULT_WIDTH = WR_WIDTH
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [NUM_WORKERS-1:0]                     RECEIVE_WR_VALID,
  input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
  output logic [NUM_WORKERS-1:0]                     RECEIVE_WR_READY,
  output logic                                       SEND_WR_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0]             SEND_WR_DATA,
  input  logic                                       SEND_WR_READY,
  output logic [$clog2(NUM_WORKERS)-1:0]             GRANT_ID,
  output logic                                       BUSY
);

  localparam int ID_W = $clog2(NUM_WORKERS);

  typedef enum logic [1:0] {
    S_ARB    = 2'd0,
    S_ACCEPT = 2'd1,
    S_SEND   = 2'd2
  } state_t;

  state_t                         state;
  logic [ID_W-1:0]                last_grant;
  logic                           found;
  logic [ID_W-1:0]                pick;
  logic [WORKER_RESULT_WIDTH-1:0] slice;

  rr_picker #(
    .N    (NUM_WORKERS),
    .ID_W (ID_W)
  ) u_picker (
    .req        (RECEIVE_WR_VALID),
    .last_grant (last_grant),
    .found      (found),
    .grant      (pick)
  );

  assign slice = RECEIVE_WR_DATA[GRANT_ID*WORKER_RESULT_WIDTH +: WORKER_RESULT_WIDTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= S_ARB;
      RECEIVE_WR_READY <= '0;
      SEND_WR_VALID    <= 1'b0;
      SEND_WR_DATA     <= '0;
      GRANT_ID         <= '0;
      BUSY             <= 1'b0;
      last_grant       <= ID_W'(NUM_WORKERS - 1);
    end else begin
      case (state)
        S_ARB: begin
          if (found) begin
            RECEIVE_WR_READY <= NUM_WORKERS'(1) << pick;
            GRANT_ID         <= pick;
            BUSY             <= 1'b1;
            state            <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          RECEIVE_WR_READY <= '0;
          if (RECEIVE_WR_VALID[GRANT_ID]) begin
            SEND_WR_DATA  <= slice;
            SEND_WR_VALID <= 1'b1;
            state         <= S_SEND;
          end else begin
            // Worker withdrew its request: abandon the grant, pointer untouched.
            BUSY  <= 1'b0;
            state <= S_ARB;
          end
        end
        S_SEND: begin
          if (SEND_WR_READY) begin
            SEND_WR_VALID <= 1'b0;
            last_grant    <= GRANT_ID;
            BUSY          <= 1'b0;
            state         <= S_ARB;
          end
        end
        default: begin
          RECEIVE_WR_READY <= '0;
          SEND_WR_VALID    <= 1'b0;
          BUSY             <= 1'b0;
          state            <= S_ARB;
        end
      endcase
    end
  end

endmodule

// File: doc/result_arbiter.md
# result_arbiter

Round-robin arbiter that merges worker-result streams from NUM_WORKERS workers into the dispatcher's single worker-result input. It accepts at most one result per transfer, registers it, and presents it downstream under valid/ready until taken. Results are forwarded unmodified; END results receive no special handling. It sits between the worker array and the dispatcher.

## Interface
- NUM_WORKERS, default 4: number of requesting workers, 2..16.
- WORKER_RESULT_WIDTH, default from the shared parameter include: width of one worker-result word.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- RECEIVE_WR_VALID  in  NUM_WORKERS  per-worker result valid; bit i belongs to worker i.
- RECEIVE_WR_DATA  in  NUM_WORKERS*WORKER_RESULT_WIDTH  packed results; worker i occupies slice [i*W +: W].
- RECEIVE_WR_READY  out  NUM_WORKERS  per-worker ready, registered, one-hot or zero.
- SEND_WR_VALID  out  1  merged result valid toward the dispatcher.
- SEND_WR_DATA  out  WORKER_RESULT_WIDTH  merged result, registered.
- SEND_WR_READY  in  1  dispatcher ready.
- GRANT_ID  out  clog2(NUM_WORKERS)  index of the worker whose result is held or being accepted.
- BUSY  out  1  high in S_ACCEPT and S_SEND.

## Operation
- FSM has 3 states:
  - S_ARB: choose a worker with RECEIVE_WR_VALID set by round-robin, starting at (last_grant+1) mod NUM_WORKERS. If one is found, set RECEIVE_WR_READY[g]=1, GRANT_ID=g and go to S_ACCEPT. If none, stay.
  - S_ACCEPT: a handshake occurs when RECEIVE_WR_VALID[g] && RECEIVE_WR_READY[g]. Then capture slice g into SEND_WR_DATA, clear READY, set SEND_WR_VALID=1 and go to S_SEND.
  - S_ACCEPT, VALID[g] low (protocol violation): clear READY, capture nothing, leave last_grant unchanged, return to S_ARB.
  - S_SEND: hold SEND_WR_VALID and SEND_WR_DATA stable until SEND_WR_VALID && SEND_WR_READY. Then clear VALID, set last_grant=g and return to S_ARB.
- Exactly one RECEIVE_WR_READY bit is high, and only in S_ACCEPT.
- Results are never dropped, duplicated or reordered within a worker.
- Fairness: after worker g is served, every other requesting worker is served before g is served again.

## Timing
- Reset values:
  - STATE=S_ARB.
  - RECEIVE_WR_READY=0.
  - SEND_WR_VALID=0, SEND_WR_DATA=0.
  - GRANT_ID=0, BUSY=0.
  - last_grant=NUM_WORKERS-1, so worker 0 has first priority.
- Latency: with VALID[i] first seen high at edge t in S_ARB:
  - READY[i] is high during cycle t+1.
  - SEND_WR_VALID is high from cycle t+2.
- Throughput: at most 1 result per 3 cycles when SEND_WR_READY is held high.
- Downstream back-pressure: SEND_WR_READY low for any number of cycles leaves data stable and all RECEIVE_WR_READY bits low.
- Simultaneous requests: round-robin order only, with no index bias beyond the starting pointer.
- Pointer wrap: last_grant = NUM_WORKERS-1 wraps the search start to 0.
- Reset mid-operation:
  - Asserting RST in any state returns all outputs to their reset values immediately (asynchronously).
  - A held result is discarded.
  - A worker that saw READY without completing the transfer keeps its VALID asserted and is re-arbitrated.
- Inputs are sampled only on the rising edge of CLK. There is no combinational path from input to output.

## Structure
- Shared param include holds WORKER_RESULT_WIDTH and DEST_OPTION_* constants.
- The existing handshake macros (sendAlways, receiveAlways) drive the VALID/READY registers.
- State encodings are local parameters inside the module.
- One sub-module, rr_picker: combinational round-robin priority picker.
  - Inputs: request vector, last_grant.
  - Outputs: found flag, grant index.
  - Implemented with a doubled-vector mask.

## Test plan
- Single request: worker 2 presents 0x…A5 with SEND_WR_READY=1 → READY[2] pulses 1 cycle later; SEND_WR_DATA=0x…A5 with VALID one cycle after that; GRANT_ID=2.
- All 4 workers valid continuously after reset → service order 0,1,2,3,0; each data word appears exactly once per grant.
- Back-pressure: SEND_WR_READY low for 10 cycles while workers 1 and 3 request → data from 1 stays stable; no READY bit rises; after release, worker 3 is served next.
- Wrap: last grant 3, requests from 0 and 3 → worker 0 is granted.
- Protocol violation: worker 1 drops VALID in S_ACCEPT → no SEND_WR_VALID; FSM is back in S_ARB next cycle; last_grant is unchanged.
- Async reset asserted in S_SEND mid-cycle → SEND_WR_VALID=0 before the next edge; after release, worker 0 has first priority.
